// File: rtl/fabric_reset_seq_pkg.sv
// Shared definitions for the fabric reset sequencer.
// Holds the sequencer state encoding, the default parameter values and the
// helper that sizes every internal counter from its limit.
package fabric_reset_seq_pkg;

  // The 3-bit codes are visible on SEQ_STATE, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_WAIT_MSS  = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_ASSERT    = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_e;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_STAGE_DLY  = 16;
  localparam int DEF_LOCK_FILT  = 8;
  localparam int DEF_TIMEOUT    = 1048576;

  // One bit of headroom above $clog2 so the limit value itself is representable.
  function automatic int cnt_w(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/fabric_reset_seq_if.sv
// Signal bundle between the sequencer and its environment.
//   slave  : sequencer side (consumes lock/ready/init/soft request, drives resets/status)
//   master : environment side (system builder outputs and user fabric logic)
// Signals:
//   FAB_CCC_LOCK, MSS_READY, INIT_DONE : asynchronous prerequisite indications
//   SOFT_RESET_REQ                     : single-cycle request, synchronous to CLK_BASE
//   STAGE_RESET_N[NUM_STAGES]          : per-domain active-low resets, bit 0 released first
//   SYS_READY, SEQ_FAULT, SEQ_STATE    : status outputs
interface fabric_reset_seq_if
  import fabric_reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
);

  logic                  FAB_CCC_LOCK;
  logic                  MSS_READY;
  logic                  INIT_DONE;
  logic                  SOFT_RESET_REQ;
  logic [NUM_STAGES-1:0] STAGE_RESET_N;
  logic                  SYS_READY;
  logic                  SEQ_FAULT;
  logic [2:0]            SEQ_STATE;

  modport master (
    output FAB_CCC_LOCK, MSS_READY, INIT_DONE, SOFT_RESET_REQ,
    input  STAGE_RESET_N, SYS_READY, SEQ_FAULT, SEQ_STATE
  );

  modport slave (
    input  FAB_CCC_LOCK, MSS_READY, INIT_DONE, SOFT_RESET_REQ,
    output STAGE_RESET_N, SYS_READY, SEQ_FAULT, SEQ_STATE
  );

endinterface

// File: rtl/fabric_reset_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with asynchronous
// active-low reset to 0. Shared with other fabric blocks.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, two destination cycles behind d_i
module seq_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Two-stage metastability filter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/fabric_reset_seq.sv
// Fabric bring-up and reset sequencer. Waits for a filtered CCC lock and for
// MSS ready plus init-done, then releases the staged reset domains one at a
// time STAGE_DLY cycles apart. Lock loss or a soft request pulls every domain
// back into reset; prerequisites that never arrive raise SEQ_FAULT.
// Ports:
//   CLK_BASE    : fabric clock
//   FAB_RESET_N : asynchronous active-low reset
//   bus         : slave side of fabric_reset_seq_if (inputs and registered outputs)
module fabric_reset_seq
  import fabric_reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STAGE_DLY  = DEF_STAGE_DLY,
  parameter int LOCK_FILT  = DEF_LOCK_FILT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic               CLK_BASE,
  input logic               FAB_RESET_N,
  fabric_reset_seq_if.slave bus
);

  localparam int DLY_MAX = NUM_STAGES * STAGE_DLY;
  localparam int FLT_W   = cnt_w(LOCK_FILT);
  localparam int TMO_W   = cnt_w(TIMEOUT);
  localparam int DLY_W   = cnt_w(DLY_MAX);

  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_END   = DLY_W'(DLY_MAX);
  localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(STAGE_DLY - 1);

  logic lock_s;
  logic rdy_s;
  logic init_s;
  logic abort_s;
  logic waiting_q_s;
  logic waiting_d_s;

  seq_state_e            state_q, state_d;
  logic [FLT_W-1:0]      filt_q, filt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;

  seq_sync2 u_sync_lock (.clk_i(CLK_BASE), .rst_ni(FAB_RESET_N), .d_i(bus.FAB_CCC_LOCK), .q_o(lock_s));
  seq_sync2 u_sync_rdy  (.clk_i(CLK_BASE), .rst_ni(FAB_RESET_N), .d_i(bus.MSS_READY),    .q_o(rdy_s));
  seq_sync2 u_sync_init (.clk_i(CLK_BASE), .rst_ni(FAB_RESET_N), .d_i(bus.INIT_DONE),    .q_o(init_s));

  // Lock loss and a soft request share one abort path, so coincident causes enter ASSERT once.
  assign abort_s = !lock_s || bus.SOFT_RESET_REQ;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (tmo_q == TMO_LAST)                     state_d = ST_FAULT;
        else if (lock_s && (filt_q == FLT_LAST))   state_d = ST_WAIT_MSS;
        else                                       state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_MSS: begin
        if (tmo_q == TMO_LAST)                     state_d = ST_FAULT;
        else if (!lock_s)                          state_d = ST_WAIT_LOCK;
        else if (rdy_s && init_s)                  state_d = ST_RELEASE;
        else                                       state_d = ST_WAIT_MSS;
      end
      ST_RELEASE: begin
        if (abort_s)                               state_d = ST_ASSERT;
        else if (dly_q == DLY_END)                 state_d = ST_RUN;
        else                                       state_d = ST_RELEASE;
      end
      ST_RUN: begin
        if (abort_s)                               state_d = ST_ASSERT;
        else                                       state_d = ST_RUN;
      end
      ST_ASSERT: begin
        if (dly_q == HOLD_LAST)                    state_d = ST_WAIT_LOCK;
        else                                       state_d = ST_ASSERT;
      end
      ST_FAULT: begin
        if (bus.SOFT_RESET_REQ)                    state_d = ST_ASSERT;
        else                                       state_d = ST_FAULT;
      end
      default:                                     state_d = ST_WAIT_LOCK;
    endcase
  end

  // Counter next values; each one is cleared by the state change that ends its use.
  always_comb begin
    filt_d      = {FLT_W{1'b0}};
    tmo_d       = {TMO_W{1'b0}};
    dly_d       = {DLY_W{1'b0}};
    waiting_q_s = (state_q == ST_WAIT_LOCK) || (state_q == ST_WAIT_MSS);
    waiting_d_s = (state_d == ST_WAIT_LOCK) || (state_d == ST_WAIT_MSS);

    // Filter counts consecutive synchronized-high lock samples while in WAIT_LOCK only.
    if ((state_q == ST_WAIT_LOCK) && lock_s && (filt_q != FLT_LAST)) filt_d = filt_q + 1'b1;
    else                                                               filt_d = {FLT_W{1'b0}};

    // Timeout spans WAIT_LOCK and WAIT_MSS together; leaving that pair clears it.
    if (waiting_q_s && waiting_d_s) tmo_d = tmo_q + 1'b1;
    else                            tmo_d = {TMO_W{1'b0}};

    // Delay counter restarts at 0 on entry to RELEASE or ASSERT.
    if ((state_d == state_q) && ((state_q == ST_RELEASE) || (state_q == ST_ASSERT)))
      dly_d = dly_q + 1'b1;
    else
      dly_d = {DLY_W{1'b0}};
  end

  // Outputs are decoded from the next state so they change on the entry edge.
  always_comb begin
    stage_d = {NUM_STAGES{1'b0}};
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_RELEASE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          stage_d[i] = (32'(dly_d) >= ((i + 1) * STAGE_DLY));
        end
      end
      ST_RUN: begin
        stage_d = {NUM_STAGES{1'b1}};
        ready_d = 1'b1;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        stage_d = {NUM_STAGES{1'b0}};
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK_BASE or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= {FLT_W{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
      dly_q   <= {DLY_W{1'b0}};
      stage_q <= {NUM_STAGES{1'b0}};
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      tmo_q   <= tmo_d;
      dly_q   <= dly_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign bus.STAGE_RESET_N = stage_q;
  assign bus.SYS_READY     = ready_q;
  assign bus.SEQ_FAULT     = fault_q;
  assign bus.SEQ_STATE     = state_q;

endmodule
